// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 8N1 serializer (start 0, 8 data bits
// LSB first, stop 1). tx, busy and done are registered.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between the
// last data bit and the stop bit (11-bit frame instead of 10).
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    din,
    input  logic                          wr,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          done
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   bcnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
`ifdef UART_TX_PARITY_EN
    logic            par;
`endif

    logic            push;
    logic            pop;
    logic            bit_end;
    logic [7:0]      rdata;
    logic [CNTW-1:0] count_nxt;

    // A write is accepted only while the registered full flag is low, so a
    // same-edge pop never rescues a byte written into a full FIFO.
    assign push    = wr && !full;
    assign bit_end = (bcnt == CW'(CLKS_PER_BIT - 1));
    // Bytes leave the FIFO only on entry to START: from IDLE, or straight out
    // of the final stop-bit cycle for gap-free back-to-back frames.
    assign pop     = (count != '0) && ((state == IDLE) || (state == STOP && bit_end));
    assign rdata   = mem[rptr];

    // Next FIFO occupancy from the push/pop pair of this cycle.
    always_comb begin
        // NOTE: assigning a default first keeps a combinational block from inferring a latch.
        count_nxt = count;
        count_nxt = count + CNTW'(push) - CNTW'(pop);
    end

    // FIFO pointers, occupancy, full and sticky overflow.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count    <= count_nxt;
            full     <= (count_nxt == CNTW'(FIFO_DEPTH));
            overflow <= overflow | (wr & full);
        end
    end

    // FIFO storage.
    // NOTE: the data array is deliberately not reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    // Serializer FSM with registered tx/busy/done and per-bit baud counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcnt  <= '0;
            idx   <= '0;
            shreg <= '0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    bcnt <= '0;
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        shreg <= rdata;
`ifdef UART_TX_PARITY_EN
                        par   <= ^rdata;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        bcnt  <= '0;
                        state <= DATA;
                        idx   <= '0;
                        tx    <= shreg[0];
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bcnt <= '0;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            shreg <= shreg >> 1;
                            tx    <= shreg[1];
                            idx   <= idx + 3'd1;
                        end
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bcnt  <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        bcnt <= '0;
                        done <= 1'b1;
                        if (pop) begin
                            state <= START;
                            tx    <= 1'b0;
                            shreg <= rdata;
`ifdef UART_TX_PARITY_EN
                            par   <= ^rdata;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    bcnt  <= '0;
                end
            endcase
        end
    end

endmodule
